pipe_wallace_tree: RTL and testbench
====================================

PIPE_WALLACE_TREE -- requirements
Module: pipe_wallace_tree

Interface
REQ-001 SHALL have parameter DW, default 16: operand and result width in bits.
REQ-002 SHALL have parameter PP, default 5: number of addends, legal range 3..16.
REQ-003 SHALL have parameter LVL_PER_STG, default 1: number of 3:2 compressor levels between pipeline registers, legal range 1..PP-2.
REQ-004 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operand set.
REQ-005 SHALL have parameter FINAL_ADD, default 0: when 1, res_o carries sum_o+carry_o; when 0, res_o is tied to 0.
REQ-006 Ports, clock and reset first; one clock; reset is synchronous and active-high:
  clk_i  in  1  clock
  rst_i  in  1  synchronous active-high reset
  valid_i  in  1  input operand set valid
  ready_o  out  1  block accepts an operand set this cycle
  add_i  in  PP x DW  packed addends
  tag_i  in  TAG_W  sideband tag
  valid_o  out  1  output valid
  ready_i  in  1  downstream accepts the output
  sum_o  out  DW  carry-save sum vector
  carry_o  out  DW  carry-save carry vector, already shifted left by one
  res_o  out  DW  resolved result (FINAL_ADD=1 only)
  tag_o  out  TAG_W  tag aligned with the output

Function
REQ-007 SHALL reduce the PP addends with a linear chain of PP-2 levels of 3:2 compressors. Level 0 takes add_i[0..2]; each level k>0 takes the previous psum, the previous carry shifted left by one, and add_i[k+2].
REQ-008 Per bit, each compressor SHALL produce sum = a^b^c and carry = majority(a,b,c). A carry shift SHALL discard bit DW-1 and insert 0 at bit 0.
REQ-009 Arithmetic invariant: sum_o+carry_o SHALL equal the sum of all add_i entries mod 2^DW.
REQ-010 NSTG = ceil((PP-2)/LVL_PER_STG) register stages. Latency from acceptance to valid_o SHALL be NSTG cycles when there is no backpressure.
REQ-011 Registers SHALL sit after levels LVL_PER_STG, 2*LVL_PER_STG, and so on, plus a final register after the last level.
REQ-012 The registers at each stage SHALL hold the psum, the shifted carry, the not-yet-consumed add_i entries, the tag, and a valid bit.
REQ-013 Acceptance occurs when valid_i && ready_o.
REQ-014 Stage s SHALL load when its valid bit is 0, or when stage s+1 loads. The last stage loads when !valid_o || ready_i.
REQ-015 ready_o SHALL equal the stage-0 load condition, so bubbles collapse and throughput is one set per cycle.
REQ-016 While valid_o && !ready_i, sum_o, carry_o, res_o and tag_o SHALL hold stable.
REQ-017 Order SHALL be preserved; no operand set is dropped or duplicated.
REQ-018 Accept and emit in the same cycle SHALL be legal with the pipeline full.
REQ-019 When FINAL_ADD=1, res_o SHALL be a combinational DW-bit add of the registered sum_o and carry_o.

Reset
REQ-020 While rst_i=1 at a clock edge, all stage valid bits SHALL clear, and valid_o SHALL be 0 from the next cycle.
REQ-021 After reset, sum_o, carry_o, res_o and tag_o SHALL read 0.
REQ-022 Reset mid-operation SHALL discard all in-flight sets.
REQ-023 ready_o SHALL be 1 in the first cycle after reset is released.

Structure
REQ-024 Package wallace_pkg SHALL hold the compressor32 function and a function computing NSTG from PP and LVL_PER_STG.
REQ-025 Sub-module csa_level SHALL implement one DW-wide row of 3:2 compressors plus the carry shift. pipe_wallace_tree SHALL instantiate it PP-2 times.
REQ-026 Illegal parameter values SHALL raise an elaboration-time error.

Verification
REQ-027 With DW=16, PP=5, LVL_PER_STG=1, ready_i=1, add_i={1,2,3,4,5} and tag 0x3: after 3 cycles, valid_o=1, sum_o+carry_o=15 and tag_o=0x3.
REQ-028 With all five addends at 0xFFFF: (sum_o+carry_o) mod 2^16 = 0xFFFB. With FINAL_ADD=1, res_o=0xFFFB.
REQ-029 Send tags 1..6 back-to-back while holding ready_i=0 for cycles 3..7:
  - ready_o drops once 3 sets are held plus the output is stalled;
  - outputs stay stable during the stall;
  - tags then emerge in order 1..6 with no loss.
REQ-030 Assert rst_i for one cycle with 2 sets in flight: valid_o=0 the next cycle, the 2 sets never emerge, and ready_o=1 after release.
REQ-031 With PP=3, LVL_PER_STG=1 and add_i={7,9,0x10}: latency 1 cycle, sum_o+carry_o=0x20.
REQ-032 Random stimulus for PP in {3,4,7,16} and LVL_PER_STG in {1,2}: a scoreboard checks REQ-009 and in-order delivery under random ready_i.

Source files
------------

// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - compressor and stage-count helpers for the pipelined carry-save adder tree
package wallace_pkg;

    // Returns {carry, sum} of a single-bit full adder.
    function automatic logic [1:0] compressor32(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Clamped to 1 so that illegal parameter sets still elaborate far enough to report their error.
    function automatic int calc_nstg(input int pp, input int lvl_per_stg);
        if (pp < 3 || lvl_per_stg < 1) begin
            return 1;
        end
        return (pp - 2 + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

    // Index of the last compressor level that feeds stage s.
    function automatic int last_lvl(input int s, input int lvl_per_stg, input int nlvl);
        int le;
        le = (s + 1) * lvl_per_stg;
        if (le > nlvl) begin
            le = nlvl;
        end
        return le - 1;
    endfunction

endpackage

// File: rtl/csa_level.sv
// rtl/csa_level.sv - one row of 3:2 compressors with the carry vector shifted left by one
module csa_level
    import wallace_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    output logic [DW-1:0] sum_o,
    output logic [DW-1:0] carry_o
);

    logic [DW-1:0] maj;

    always_comb begin
        sum_o = '0;
        maj   = '0;
        for (int i = 0; i < DW; i++) begin
            {maj[i], sum_o[i]} = compressor32(a_i[i], b_i[i], c_i[i]);
        end
    end

    // The top majority bit falls off: results are modulo 2^DW.
    assign carry_o = maj << 1;

endmodule

// File: rtl/pipe_wallace_tree.sv
// rtl/pipe_wallace_tree.sv - linear 3:2 compressor chain with elastic pipeline registers
module pipe_wallace_tree
    import wallace_pkg::*;
#(
    parameter int DW          = 16,
    parameter int PP          = 5,
    parameter int LVL_PER_STG = 1,
    parameter int TAG_W       = 4,
    parameter int FINAL_ADD   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [PP-1:0][DW-1:0]  add_i,
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DW-1:0]          sum_o,
    output logic [DW-1:0]          carry_o,
    output logic [DW-1:0]          res_o,
    output logic [TAG_W-1:0]       tag_o
);

    localparam int NLVL = PP - 2;
    localparam int NSTG = calc_nstg(PP, LVL_PER_STG);

    if (PP < 3 || PP > 16) begin : g_bad_pp
        $error("pipe_wallace_tree: PP must be in 3..16");
    end
    if (LVL_PER_STG < 1 || LVL_PER_STG > PP - 2) begin : g_bad_lvl
        $error("pipe_wallace_tree: LVL_PER_STG must be in 1..PP-2");
    end
    if (DW < 1 || TAG_W < 1) begin : g_bad_w
        $error("pipe_wallace_tree: DW and TAG_W must be positive");
    end
    if (FINAL_ADD != 0 && FINAL_ADD != 1) begin : g_bad_fa
        $error("pipe_wallace_tree: FINAL_ADD must be 0 or 1");
    end

    logic [NSTG-1:0]  vld_q, vld_d, load;
    logic [DW-1:0]    sum_q   [NSTG];
    logic [DW-1:0]    sum_d   [NSTG];
    logic [DW-1:0]    carry_q [NSTG];
    logic [DW-1:0]    carry_d [NSTG];
    logic [TAG_W-1:0] tag_q   [NSTG];
    logic [TAG_W-1:0] tag_d   [NSTG];
    logic [DW-1:0]    rem_q   [NSTG][PP];
    logic [DW-1:0]    rem_d   [NSTG][PP];
    logic [DW-1:0]    stg_sum [NSTG];
    logic [DW-1:0]    stg_car [NSTG];

    // Level k belongs to stage k/LVL_PER_STG; the first level of a stage reads the previous registers.
    for (genvar k = 0; k < NLVL; k++) begin : g_lvl
        localparam int S = k / LVL_PER_STG;
        logic [DW-1:0] a_w, b_w, c_w, s_w, co_w;

        if (k == 0) begin : g_head
            assign a_w = add_i[0];
            assign b_w = add_i[1];
            assign c_w = add_i[2];
        end else if (k == S * LVL_PER_STG) begin : g_reg_in
            assign a_w = sum_q[S-1];
            assign b_w = carry_q[S-1];
            assign c_w = rem_q[S-1][k+2];
        end else if (S == 0) begin : g_chain_in
            assign a_w = g_lvl[k-1].s_w;
            assign b_w = g_lvl[k-1].co_w;
            assign c_w = add_i[k+2];
        end else begin : g_chain_reg
            assign a_w = g_lvl[k-1].s_w;
            assign b_w = g_lvl[k-1].co_w;
            assign c_w = rem_q[S-1][k+2];
        end

        csa_level #(.DW(DW)) u_csa (
            .a_i     (a_w),
            .b_i     (b_w),
            .c_i     (c_w),
            .sum_o   (s_w),
            .carry_o (co_w)
        );
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stg_out
        localparam int LE = last_lvl(s, LVL_PER_STG, NLVL);
        assign stg_sum[s] = g_lvl[LE].s_w;
        assign stg_car[s] = g_lvl[LE].co_w;
    end

    always_comb begin
        vld_d   = vld_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        tag_d   = tag_q;
        rem_d   = rem_q;
        load    = '0;

        load[NSTG-1] = !vld_q[NSTG-1] || ready_i;
        for (int s = NSTG - 2; s >= 0; s--) begin
            load[s] = !vld_q[s] || load[s+1];
        end

        // Payload only moves with a valid set so idle registers keep their last (or reset) contents.
        if (load[0]) begin
            vld_d[0] = valid_i;
            if (valid_i) begin
                sum_d[0]   = stg_sum[0];
                carry_d[0] = stg_car[0];
                tag_d[0]   = tag_i;
                for (int j = 0; j < PP; j++) begin
                    if (j >= last_lvl(0, LVL_PER_STG, NLVL) + 3) begin
                        rem_d[0][j] = add_i[j];
                    end
                end
            end
        end

        for (int s = 1; s < NSTG; s++) begin
            if (load[s]) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    sum_d[s]   = stg_sum[s];
                    carry_d[s] = stg_car[s];
                    tag_d[s]   = tag_q[s-1];
                    for (int j = 0; j < PP; j++) begin
                        if (j >= last_lvl(s, LVL_PER_STG, NLVL) + 3) begin
                            rem_d[s][j] = rem_q[s-1][j];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            sum_q   <= '{default: '0};
            carry_q <= '{default: '0};
            tag_q   <= '{default: '0};
            rem_q   <= '{default: '0};
        end else begin
            vld_q   <= vld_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            tag_q   <= tag_d;
            rem_q   <= rem_d;
        end
    end

    assign ready_o = load[0];
    assign valid_o = vld_q[NSTG-1];
    assign sum_o   = sum_q[NSTG-1];
    assign carry_o = carry_q[NSTG-1];
    assign tag_o   = tag_q[NSTG-1];

    if (FINAL_ADD == 1) begin : g_final_add
        assign res_o = sum_o + carry_o;
    end else begin : g_no_final_add
        assign res_o = '0;
    end

endmodule

// File: tb/tb_pipe_wallace_tree.sv
// tb/tb_pipe_wallace_tree.sv - directed and randomized scoreboard bench for pipe_wallace_tree
module tb_pipe_wallace_tree;

    logic clk;
    logic rst;
    logic rst_r;
    int   n_vec;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Main instance: DW=16, PP=5, LVL_PER_STG=1, FINAL_ADD=1
    logic             d_valid, d_ready_o, d_valid_o, d_ready;
    logic [4:0][15:0] d_add;
    logic [3:0]       d_tag, d_tag_o;
    logic [15:0]      d_sum, d_carry, d_res;

    pipe_wallace_tree #(.DW(16), .PP(5), .LVL_PER_STG(1), .TAG_W(4), .FINAL_ADD(1)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (d_valid),
        .ready_o (d_ready_o),
        .add_i   (d_add),
        .tag_i   (d_tag),
        .valid_o (d_valid_o),
        .ready_i (d_ready),
        .sum_o   (d_sum),
        .carry_o (d_carry),
        .res_o   (d_res),
        .tag_o   (d_tag_o)
    );

    // PP=3 instance: single level, single stage
    logic             t_valid, t_ready_o, t_valid_o, t_ready;
    logic [2:0][15:0] t_add;
    logic [3:0]       t_tag, t_tag_o;
    logic [15:0]      t_sum, t_carry, t_res;

    pipe_wallace_tree #(.DW(16), .PP(3), .LVL_PER_STG(1), .TAG_W(4), .FINAL_ADD(1)) u_pp3 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (t_valid),
        .ready_o (t_ready_o),
        .add_i   (t_add),
        .tag_i   (t_tag),
        .valid_o (t_valid_o),
        .ready_i (t_ready),
        .sum_o   (t_sum),
        .carry_o (t_carry),
        .res_o   (t_res),
        .tag_o   (t_tag_o)
    );

    initial begin
        rst_r = 1'b1;
        repeat (3) @(negedge clk);
        rst_r = 1'b0;
    end

    // Randomized configurations, each with its own queue-based reference model
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int P = (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 7 : 16;
        localparam int L = (g == 0 || g == 2) ? 1 : 2;

        logic             vi, ro, vo, ri;
        logic [P-1:0][15:0] ad;
        logic [3:0]       ti, to;
        logic [15:0]      so, co, reso;
        logic             done;

        pipe_wallace_tree #(.DW(16), .PP(P), .LVL_PER_STG(L), .TAG_W(4), .FINAL_ADD(1)) u_rdut (
            .clk_i   (clk),
            .rst_i   (rst_r),
            .valid_i (vi),
            .ready_o (ro),
            .add_i   (ad),
            .tag_i   (ti),
            .valid_o (vo),
            .ready_i (ri),
            .sum_o   (so),
            .carry_o (co),
            .res_o   (reso),
            .tag_o   (to)
        );

        initial begin
            logic [19:0] q[$];
            logic [19:0] e;
            logic [15:0] ref_sum, hs, hc, hr;
            logic [3:0]  ht;
            logic        pstall;
            done   = 1'b0;
            vi     = 1'b0;
            ri     = 1'b0;
            ad     = '0;
            ti     = '0;
            pstall = 1'b0;
            hs = '0; hc = '0; hr = '0; ht = '0;
            repeat (4) @(negedge clk);
            for (int cyc = 0; cyc < 500; cyc++) begin
                if (cyc >= 400 && q.size() == 0) break;
                if (cyc < 400) begin
                    vi = ($urandom_range(0, 3) != 0);
                    ri = ($urandom_range(0, 3) != 0);
                    for (int p = 0; p < P; p++) ad[p] = 16'($urandom);
                    ti = 4'($urandom);
                end else begin
                    vi = 1'b0;
                    ri = 1'b1;
                end
                #1;
                if (pstall) begin
                    check("rnd_hold_sum", so, hs);
                    check("rnd_hold_carry", co, hc);
                    check("rnd_hold_tag", to, ht);
                    check("rnd_hold_res", reso, hr);
                end
                if (vo && ri) begin
                    if (q.size() == 0) begin
                        check("rnd_spurious_valid", vo, 1'b0);
                    end else begin
                        e = q.pop_front();
                        check("rnd_sum", 16'(so + co), e[15:0]);
                        check("rnd_tag", to, e[19:16]);
                        check("rnd_res", reso, e[15:0]);
                    end
                end
                pstall = vo && !ri;
                hs = so; hc = co; ht = to; hr = reso;
                if (vi && ro) begin
                    ref_sum = '0;
                    for (int p = 0; p < P; p++) ref_sum = ref_sum + ad[p];
                    q.push_back({ti, ref_sum});
                end
                @(negedge clk);
            end
            check("rnd_drain_left", q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        int          nsent, nrecv, nseen;
        logic        pstall;
        logic [15:0] hs, hc, hr;
        logic [3:0]  ht;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        d_valid = 1'b0;
        d_ready = 1'b0;
        d_add   = '0;
        d_tag   = '0;
        t_valid = 1'b0;
        t_ready = 1'b1;
        t_add   = '0;
        t_tag   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid_o", d_valid_o, 1'b0);
        check("rst_sum_o", d_sum, 16'h0);
        check("rst_carry_o", d_carry, 16'h0);
        check("rst_res_o", d_res, 16'h0);
        check("rst_tag_o", d_tag_o, 4'h0);
        check("rst_ready_o", d_ready_o, 1'b1);

        // Small operands: latency 3
        d_valid = 1'b1;
        d_ready = 1'b1;
        d_add   = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        d_tag   = 4'h3;
        @(negedge clk);
        d_valid = 1'b0;
        #1 check("lat_c1_valid_o", d_valid_o, 1'b0);
        @(negedge clk);
        #1 check("lat_c2_valid_o", d_valid_o, 1'b0);
        @(negedge clk);
        #1;
        check("lat_c3_valid_o", d_valid_o, 1'b1);
        check("small_sum", 16'(d_sum + d_carry), 16'd15);
        check("small_tag", d_tag_o, 4'h3);
        check("small_res", d_res, 16'd15);

        // All-ones operands wrap modulo 2^16
        d_valid = 1'b1;
        d_add   = {5{16'hFFFF}};
        d_tag   = 4'h5;
        @(negedge clk);
        d_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (d_valid_o) break;
            @(negedge clk);
        end
        check("ones_valid_o", d_valid_o, 1'b1);
        check("ones_sum", 16'(d_sum + d_carry), 16'hFFFB);
        check("ones_res", d_res, 16'hFFFB);
        check("ones_tag", d_tag_o, 4'h5);
        @(negedge clk);
        @(negedge clk);

        // Back-to-back tags 1..6 with output stalled in cycles 3..7
        nsent  = 0;
        nrecv  = 0;
        pstall = 1'b0;
        hs = '0; hc = '0; hr = '0; ht = '0;
        for (int c = 0; c < 40 && nrecv < 6; c++) begin
            d_ready = !(c >= 3 && c <= 7);
            d_valid = (nsent < 6);
            d_tag   = 4'(nsent + 1);
            for (int p = 0; p < 5; p++) d_add[p] = 16'(nsent + 1);
            #1;
            if (nsent < 6) check("stall_ready_o", d_ready_o, d_ready);
            if (pstall) begin
                check("stall_hold_sum", d_sum, hs);
                check("stall_hold_carry", d_carry, hc);
                check("stall_hold_tag", d_tag_o, ht);
                check("stall_hold_res", d_res, hr);
            end
            if (d_valid_o && d_ready) begin
                nrecv++;
                check("stall_order_tag", d_tag_o, 4'(nrecv));
                check("stall_sum", 16'(d_sum + d_carry), 16'(5 * nrecv));
            end
            pstall = d_valid_o && !d_ready;
            hs = d_sum; hc = d_carry; ht = d_tag_o; hr = d_res;
            if (d_valid && d_ready_o) nsent++;
            @(negedge clk);
        end
        d_valid = 1'b0;
        check("stall_recv_count", nrecv, 6);

        // Reset with two sets in flight
        d_ready = 1'b1;
        d_valid = 1'b1;
        d_tag   = 4'h9;
        d_add   = {5{16'h0101}};
        @(negedge clk);
        d_tag   = 4'hA;
        @(negedge clk);
        d_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid_o", d_valid_o, 1'b0);
        check("midrst_ready_o", d_ready_o, 1'b1);
        check("midrst_sum_o", d_sum, 16'h0);
        check("midrst_tag_o", d_tag_o, 4'h0);
        nseen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (d_valid_o) nseen++;
        end
        check("midrst_emitted", nseen, 0);

        // PP=3: one level, one stage
        t_valid = 1'b1;
        t_add   = {16'h10, 16'd9, 16'd7};
        t_tag   = 4'h6;
        #1 check("pp3_pre_valid_o", t_valid_o, 1'b0);
        @(negedge clk);
        t_valid = 1'b0;
        #1;
        check("pp3_valid_o", t_valid_o, 1'b1);
        check("pp3_sum", 16'(t_sum + t_carry), 16'h20);
        check("pp3_res", t_res, 16'h20);
        check("pp3_tag", t_tag_o, 4'h6);

        for (int i = 0; i < 5000; i++) begin
            if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done) break;
            @(negedge clk);
        end
        check("rnd_all_done", {g_rnd[3].done, g_rnd[2].done, g_rnd[1].done, g_rnd[0].done}, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
